// File: rtl/uart_tx.sv
// UART transmitter: one byte per frame, LSB first, on an idle-high line.
// Optional parity bit, one or two stop bits. Runs on clk with an internal baud divider.
//
// state  | meaning
// IDLE   | line high, tx_ready high, waiting for start_tx
// START  | start bit (low) for one bit period
// DATA   | eight data bits, LSB first
// PARITY | parity bit, only when parity is enabled
// STOP   | stop bit(s) high; done_tx pulses after the last one
module uart_tx #(
    parameter int clk_freq    = 1000000,
    parameter int baud        = 9600,
    parameter int parity_mode = 0,
    parameter int stop_bits   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_tx,
    input  logic [7:0] din_tx,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy_tx,
    output logic       done_tx
);

    localparam int DIV     = clk_freq / baud;
    localparam int CW      = $clog2(DIV);
    localparam bit PAR_ON  = (parity_mode == 1) || (parity_mode == 2);
    localparam bit PAR_ODD = (parity_mode == 1);
    localparam int STOPS   = (stop_bits == 2) ? 2 : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOPS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   baud_cnt, baud_cnt_nxt;
    logic [2:0]      bit_cnt, bit_cnt_nxt;
    logic [7:0]      shift, shift_nxt;
    logic            parity_bit, parity_nxt;
    logic            tx_nxt, tx_ready_nxt, busy_nxt, done_nxt;
    logic            tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            tx_ready   <= 1'b1;
            busy_tx    <= 1'b0;
            done_tx    <= 1'b0;
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift      <= shift_nxt;
            parity_bit <= parity_nxt;
            tx         <= tx_nxt;
            tx_ready   <= tx_ready_nxt;
            busy_tx    <= busy_nxt;
            done_tx    <= done_nxt;
        end
    end

    // Every output is computed one cycle ahead so tx and the handshake flags come straight from flops.
    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift;
        parity_nxt   = parity_bit;
        tx_nxt       = tx;
        tx_ready_nxt = tx_ready;
        busy_nxt     = busy_tx;
        done_nxt     = 1'b0;
        tick         = (baud_cnt == CNT_LAST);

        if (state != IDLE) begin
            baud_cnt_nxt = tick ? '0 : baud_cnt + CW'(1);
        end

        case (state)
            IDLE: begin
                if (start_tx && tx_ready) begin
                    shift_nxt    = din_tx;
                    parity_nxt   = PAR_ODD ? ~^din_tx : ^din_tx;
                    state_nxt    = START;
                    baud_cnt_nxt = '0;
                    bit_cnt_nxt  = '0;
                    tx_nxt       = 1'b0;
                    tx_ready_nxt = 1'b0;
                    busy_nxt     = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                    tx_nxt    = shift[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_nxt = '0;
                        if (PAR_ON) begin
                            state_nxt = PARITY;
                            tx_nxt    = parity_bit;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        tx_nxt      = shift[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_nxt   = STOP;
                    bit_cnt_nxt = '0;
                    tx_nxt      = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt == STOP_LAST) begin
                        state_nxt    = IDLE;
                        bit_cnt_nxt  = '0;
                        done_nxt     = 1'b1;
                        tx_ready_nxt = 1'b1;
                        busy_nxt     = 1'b0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_nxt    = IDLE;
                tx_nxt       = 1'b1;
                tx_ready_nxt = 1'b1;
                busy_nxt     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances cover no parity / odd+2 stop / even parity.
// Frame bit patterns are hand-written (bit 0 = start bit, first on the line).
module tb_uart_tx;

    localparam int DIV = 104;

    logic       clk;
    logic       rst;
    logic [2:0] start_v;
    logic [7:0] din;
    logic       tx0, tx1, tx2;
    logic       rdy0, rdy1, rdy2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic [2:0] tx_v, ready_v, busy_v, done_v;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt0 = 0;
    int done_cnt2 = 0;
    int rx_cnt = 0;
    logic [7:0] rx_shift;
    logic [7:0] rx_bytes [4];
    int snap;

    assign tx_v    = {tx2, tx1, tx0};
    assign ready_v = {rdy2, rdy1, rdy0};
    assign busy_v  = {busy2, busy1, busy0};
    assign done_v  = {done2, done1, done0};

    uart_tx u0 (
        .clk(clk), .rst(rst), .start_tx(start_v[0]), .din_tx(din),
        .tx_ready(rdy0), .tx(tx0), .busy_tx(busy0), .done_tx(done0)
    );

    uart_tx #(.parity_mode(1), .stop_bits(2)) u1 (
        .clk(clk), .rst(rst), .start_tx(start_v[1]), .din_tx(din),
        .tx_ready(rdy1), .tx(tx1), .busy_tx(busy1), .done_tx(done1)
    );

    uart_tx #(.parity_mode(2), .stop_bits(1)) u2 (
        .clk(clk), .rst(rst), .start_tx(start_v[2]), .din_tx(din),
        .tx_ready(rdy2), .tx(tx2), .busy_tx(busy2), .done_tx(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done0 === 1'b1) done_cnt0 <= done_cnt0 + 1;
        if (done2 === 1'b1) done_cnt2 <= done_cnt2 + 1;
    end

    // Loopback receiver for the even-parity instance: mid-bit sampling, 11-bit frames.
    always @(negedge tx2) begin
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            rx_shift[i] = tx2;
        end
        repeat (2 * DIV) @(negedge clk);
        if (rx_cnt < 4) rx_bytes[rx_cnt] = rx_shift;
        rx_cnt = rx_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller has set start_v[sel] at a negedge; the next posedge accepts the byte.
    task automatic run_frame(input int sel, input logic [15:0] bits, input int nbits,
                             input bit hold, input string tag);
        int bad_lvl;
        int bad_ctl;
        bad_ctl = 0;
        for (int b = 0; b < nbits; b++) begin
            bad_lvl = 0;
            for (int c = 0; c < DIV; c++) begin
                @(negedge clk);
                if (!hold && b == 0 && c == 0) start_v[sel] = 1'b0;
                if (tx_v[sel] !== bits[b]) bad_lvl++;
                if (busy_v[sel] !== 1'b1 || ready_v[sel] !== 1'b0 || done_v[sel] !== 1'b0)
                    bad_ctl++;
            end
            check($sformatf("%s bit%0d cycles off-level", tag, b), bad_lvl, 0);
        end
        check($sformatf("%s busy/ready/done during frame", tag), bad_ctl, 0);
        @(negedge clk);
        check($sformatf("%s done_tx at end", tag), done_v[sel], 1);
        check($sformatf("%s tx_ready at end", tag), ready_v[sel], 1);
        check($sformatf("%s busy_tx at end", tag), busy_v[sel], 0);
        check($sformatf("%s tx at end", tag), tx_v[sel], 1);
    endtask

    initial begin
        int bad;
        rst     = 1'b1;
        start_v = 3'b000;
        din     = 8'h00;
        #12;
        check("reset tx", tx0, 1);
        check("reset tx_ready", rdy0, 1);
        check("reset busy_tx", busy0, 0);
        check("reset done_tx", done0, 0);
        @(negedge clk);
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || rdy0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) bad++;
        end
        check("idle 500 cycles", bad, 0);
        check("idle no done pulse", done_cnt0, 0);

        // Defaults, 0xA5: 0,1,0,1,0,0,1,0,1,1
        din = 8'hA5; start_v[0] = 1'b1;
        run_frame(0, 16'h034A, 10, 1'b0, "a5");
        repeat (3) @(negedge clk);
        check("a5 done pulse count", done_cnt0, 1);

        // Odd parity, 2 stops, 0x03: 0,1,1,0,0,0,0,0,0,1,1,1 (1248 cycles)
        din = 8'h03; start_v[1] = 1'b1;
        run_frame(1, 16'h0E06, 12, 1'b0, "odd03");
        repeat (3) @(negedge clk);

        // Even parity back-to-back with start_tx held
        din = 8'h00; start_v[2] = 1'b1;
        run_frame(2, 16'h0400, 11, 1'b1, "even00");
        din = 8'hFF;
        run_frame(2, 16'h05FE, 11, 1'b1, "evenFF");
        din = 8'h5A;
        run_frame(2, 16'h04B4, 11, 1'b0, "even5A");
        repeat (3) @(negedge clk);
        check("loopback byte count", rx_cnt, 3);
        check("loopback byte0", rx_bytes[0], 8'h00);
        check("loopback byte1", rx_bytes[1], 8'hFF);
        check("loopback byte2", rx_bytes[2], 8'h5A);
        check("back-to-back done pulses", done_cnt2, 3);

        // start_tx with 0x11 during DATA of a 0x3C frame is dropped
        din = 8'h3C; start_v[0] = 1'b1;
        fork
            run_frame(0, 16'h0278, 10, 1'b0, "3c");
            begin
                repeat (300) @(negedge clk);
                din = 8'h11; start_v[0] = 1'b1;
                @(negedge clk);
                start_v[0] = 1'b0;
            end
        join
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
        end
        check("busy start dropped", bad, 0);
        check("3c done pulse count", done_cnt0, 2);

        // Asynchronous reset mid-frame
        din = 8'h00; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (299) @(negedge clk);
        check("pre-reset tx low", tx0, 0);
        snap = done_cnt0;
        #1 rst = 1'b1;
        #1;
        check("async reset tx", tx0, 1);
        check("async reset busy_tx", busy0, 0);
        check("async reset tx_ready", rdy0, 1);
        check("async reset done_tx", done0, 0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset no done pulse", done_cnt0, snap);

        // 0x7E after reset: 0,0,1,1,1,1,1,1,0,1
        din = 8'h7E; start_v[0] = 1'b1;
        run_frame(0, 16'h02FC, 10, 1'b0, "7e");
        repeat (3) @(negedge clk);
        check("7e done pulse count", done_cnt0, snap + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
